up_counter_mod: RTL and testbench

- Parameterized modulo up-counter; the count-up counterpart of the team's 4-bit ripple-free down counter.
- Counts 0 -> MAX_VAL, then wraps to 0, or holds at MAX_VAL when saturate mode is selected.
- Supports parallel load, count enable and synchronous clear.
- Outputs a one-cycle terminal-count pulse and a sticky wrap flag, used as a timebase or event counter alongside the down counter.

---
 rtl/up_counter_mod_if.sv | 30 +++
 rtl/up_counter_mod.sv | 73 +++++++
 tb/tb_up_counter_mod.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/up_counter_mod_if.sv
// Control/status bundle for the modulo up-counter.
// Signal protocol: there is no valid/ready handshake on this bus. Every
// control input (en, clr, load, din, sat, ack) is a level sampled on each
// rising clk edge, and every status output (q, tc, wrapped) is a registered
// level that is stable for the whole cycle that follows that edge.
interface up_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] din;
  logic             sat;
  logic             ack;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrapped;

  // Controller side: drives the controls, observes the count.
  modport master (
    output en, clr, load, din, sat, ack,
    input  q, tc, wrapped
  );

  // Counter side: consumes the controls, drives the count.
  modport slave (
    input  en, clr, load, din, sat, ack,
    output q, tc, wrapped
  );
endinterface

// File: rtl/up_counter_mod.sv
// Parameterized modulo up-counter: counts 0..MAX_VAL, then wraps to 0 or
// holds at MAX_VAL in saturate mode. Supports synchronous clear and a
// clamped parallel load, and reports a registered one-cycle terminal-count
// pulse plus a sticky wrap flag that is cleared by ack.
// Legal parameters: 2 <= WIDTH <= 16, 1 <= MAX_VAL <= 2**WIDTH-1.
module up_counter_mod #(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = 15
) (
  input  logic         clk,
  input  logic         rst,   // asynchronous, active low
  up_counter_if.slave  bus
);

  // Terminal count in the counter width and in the one-bit-wider form used
  // for compares against the incremented value and the load value.
  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VAL);

  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic             wrapped_q, wrapped_d;
  logic [WIDTH:0]   q_inc;
  logic [WIDTH:0]   din_ext;
  logic             wrap_evt;

  // q+1 carries into an extra bit so MAX_VAL == 2**WIDTH-1 is compared
  // exactly instead of silently overflowing back to zero.
  assign q_inc   = {1'b0, q_q} + (WIDTH+1)'(1);
  assign din_ext = {1'b0, bus.din};

  // Next-state: clr beats load beats en; tc only marks entry into MAX_VAL
  // in sat mode or a wrap in wrap mode, so a held saturation gives tc=0.
  always_comb begin
    q_d      = q_q;
    tc_d     = 1'b0;
    wrap_evt = 1'b0;
    if (bus.clr) begin
      q_d = '0;
    end else if (bus.load) begin
      q_d = (din_ext > MAX_EXT) ? MAX_Q : bus.din;
    end else if (bus.en) begin
      if (q_inc <= MAX_EXT) begin
        q_d  = q_inc[WIDTH-1:0];
        tc_d = bus.sat && (q_inc == MAX_EXT);
      end else if (!bus.sat) begin
        q_d      = '0;
        tc_d     = 1'b1;
        wrap_evt = 1'b1;
      end
    end
    // A wrap on the same edge as ack wins, keeping the flag set.
    wrapped_d = wrap_evt | (wrapped_q & ~bus.ack);
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q       <= '0;
      tc_q      <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      tc_q      <= tc_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign bus.q       = q_q;
  assign bus.tc      = tc_q;
  assign bus.wrapped = wrapped_q;

endmodule

// File: tb/tb_up_counter_mod.sv
// Self-checking bench for up_counter_mod: two instances (MAX_VAL=15 and a
// non-power-of-two MAX_VAL=9) driven by directed steps and then random
// stimulus, checked against a behavioural counter model.
module tb_up_counter_mod;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  up_counter_if #(.WIDTH(4)) if15 ();
  up_counter_if #(.WIDTH(4)) if9 ();

  up_counter_mod #(.WIDTH(4), .MAX_VAL(15)) dut15 (
    .clk (clk),
    .rst (rst),
    .bus (if15)
  );

  up_counter_mod #(.WIDTH(4), .MAX_VAL(9)) dut9 (
    .clk (clk),
    .rst (rst),
    .bus (if9)
  );

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state for each instance.
  int m15_q, m15_tc, m15_w;
  int m9_q,  m9_tc,  m9_w;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Counter behaviour from its rules: priority clr > load > en > hold.
  task automatic model_step(input int maxv, inout int mq, inout int mtc, inout int mw,
                            input logic en, input logic clr, input logic load,
                            input logic sat, input logic ack, input int din);
    int nq;
    int ntc;
    bit wrap;
    nq   = mq;
    ntc  = 0;
    wrap = 0;
    if (clr) begin
      nq = 0;
    end else if (load) begin
      nq = (din > maxv) ? maxv : din;
    end else if (en) begin
      if (mq < maxv) begin
        nq = mq + 1;
        if (sat && nq == maxv) ntc = 1;
      end else if (!sat) begin
        nq   = 0;
        ntc  = 1;
        wrap = 1;
      end
    end
    mq  = nq;
    mtc = ntc;
    if (wrap) mw = 1;
    else if (ack) mw = 0;
  endtask

  task automatic model_reset();
    m15_q = 0; m15_tc = 0; m15_w = 0;
    m9_q  = 0; m9_tc  = 0; m9_w  = 0;
  endtask

  task automatic check_all();
    chk("q15",  32'(if15.q),       32'(m15_q));
    chk("tc15", 32'(if15.tc),      32'(m15_tc));
    chk("w15",  32'(if15.wrapped), 32'(m15_w));
    chk("q9",   32'(if9.q),        32'(m9_q));
    chk("tc9",  32'(if9.tc),       32'(m9_tc));
    chk("w9",   32'(if9.wrapped),  32'(m9_w));
  endtask

  // ---------------- driver tasks ----------------
  // One clock edge: advance the model with the inputs being applied, then
  // sample outputs 1 time unit after the edge.
  task automatic tick();
    model_step(15, m15_q, m15_tc, m15_w, if15.en, if15.clr, if15.load,
               if15.sat, if15.ack, int'(if15.din));
    model_step(9, m9_q, m9_tc, m9_w, if9.en, if9.clr, if9.load,
               if9.sat, if9.ack, int'(if9.din));
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive15(input logic en, input logic clr, input logic load,
                         input logic [3:0] din, input logic sat, input logic ack);
    if15.en = en; if15.clr = clr; if15.load = load;
    if15.din = din; if15.sat = sat; if15.ack = ack;
  endtask

  task automatic drive9(input logic en, input logic clr, input logic load,
                        input logic [3:0] din, input logic sat, input logic ack);
    if9.en = en; if9.clr = clr; if9.load = load;
    if9.din = din; if9.sat = sat; if9.ack = ack;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int pulses;
    int max_q;
    int tc_at_q15;

    drive15(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    drive9 (1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b1;

    // Reset and count: async reset at q=7, then full 0..15 run and wrap.
    drive15(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    chk("pre_reset_q", 32'(if15.q), 32'd7);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("async_rst_q",  32'(if15.q),       32'd0);
    chk("async_rst_tc", 32'(if15.tc),      32'd0);
    chk("async_rst_w",  32'(if15.wrapped), 32'd0);
    #3;
    rst = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk("count_seq", 32'(if15.q), 32'(i));
    end
    tick();
    chk("wrap_q",  32'(if15.q),       32'd0);
    chk("wrap_tc", 32'(if15.tc),      32'd1);
    chk("wrap_w",  32'(if15.wrapped), 32'd1);
    if15.en = 1'b0;
    tick();
    chk("tc_one_cycle", 32'(if15.tc),      32'd0);
    chk("w_sticky",     32'(if15.wrapped), 32'd1);

    // Non-power-of-two modulus: 0..9,0..9,0..4.
    drive9(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    pulses = 0;
    max_q  = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (if9.tc === 1'b1) pulses++;
      if (int'(if9.q) > max_q) max_q = int'(if9.q);
    end
    chk("mod9_end_q",  32'(if9.q), 32'd4);
    chk("mod9_pulses", 32'(pulses), 32'd2);
    chk("mod9_max_q",  32'(max_q),  32'd9);
    if9.en = 1'b0;

    // Saturate: load 12 (ack clears the earlier wrap), then 6 enabled edges.
    drive15(1'b0, 1'b0, 1'b1, 4'd12, 1'b1, 1'b1);
    tick();
    chk("sat_load_q", 32'(if15.q),       32'd12);
    chk("sat_load_w", 32'(if15.wrapped), 32'd0);
    drive15(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    pulses    = 0;
    tc_at_q15 = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (if15.tc === 1'b1) begin
        pulses++;
        if (i == 2) tc_at_q15 = 1;
      end
      chk("sat_w_low", 32'(if15.wrapped), 32'd0);
    end
    chk("sat_q",        32'(if15.q),     32'd15);
    chk("sat_pulses",   32'(pulses),     32'd1);
    chk("sat_tc_entry", 32'(tc_at_q15),  32'd1);

    // Mode switch at boundary: drop sat while holding at 15.
    if15.sat = 1'b0;
    tick();
    chk("switch_q",  32'(if15.q),       32'd0);
    chk("switch_tc", 32'(if15.tc),      32'd1);
    chk("switch_w",  32'(if15.wrapped), 32'd1);
    if15.en = 1'b0;

    // Priority and clamping on the MAX_VAL=9 instance.
    drive9(1'b1, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0);
    tick();
    chk("prio_clr_q", 32'(if9.q), 32'd0);
    drive9(1'b0, 1'b0, 1'b1, 4'd14, 1'b0, 1'b0);
    tick();
    chk("clamp_q", 32'(if9.q), 32'd9);
    drive9(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_q", 32'(if9.q), 32'd9);
    end

    // Sticky flag race: wrap and ack on the same edge, set wins.
    chk("race_pre_w", 32'(if9.wrapped), 32'd1);
    drive9(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    tick();
    chk("race_q",  32'(if9.q),       32'd0);
    chk("race_w",  32'(if9.wrapped), 32'd1);
    drive9(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    tick();
    chk("ack_clr_w", 32'(if9.wrapped), 32'd0);
    if9.ack = 1'b0;

    // Random stimulus against the model.
    for (int i = 0; i < 400; i++) begin
      drive15(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0),
              1'($urandom_range(0, 11) == 0), 4'($urandom_range(0, 15)),
              ($urandom_range(0, 15) == 0) ? ~if15.sat : if15.sat,
              1'($urandom_range(0, 7) == 0));
      drive9 (1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0),
              1'($urandom_range(0, 11) == 0), 4'($urandom_range(0, 15)),
              ($urandom_range(0, 15) == 0) ? ~if9.sat : if9.sat,
              1'($urandom_range(0, 7) == 0));
      tick();
    end

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
